// File: rtl/fifo_disp_pkg.sv
// Shared constants for the FIFO status display: active-low {a..g} glyphs,
// blank pattern, digit count and default refresh divider.
package fifo_disp_pkg;

    localparam int NUM_DIGITS          = 8;
    localparam int DEFAULT_REFRESH_DIV = 100000;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index is the hex value; bit 6 is segment a, bit 0 is segment g.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment {a..g} decoder.
module hex_to_seg
    import fifo_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_GLYPH[nibble];
    end

endmodule

// File: rtl/fifo_display_driver.sv
// Eight-digit multiplexed display of the last FIFO read byte and the full/empty flags.
// Define FIFO_DISP_COUNT_EN to build an 8-bit read counter shown on digits 5:4.
module fifo_display_driver
    import fifo_disp_pkg::*;
#(
    parameter int DSIZE       = 8,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rd_strobe,
    input  logic             wfull,
    input  logic             rempty,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             f,
    output logic             g,
    output logic [7:0]       anode
);

    localparam int              PW   = $clog2(REFRESH_DIV);
    localparam int              SW   = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0]   LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [SW-1:0] scan_idx;
    logic [7:0]    capture;
    logic [6:0]    seg_q;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    glyph;

`ifdef FIFO_DISP_COUNT_EN
    logic [7:0]    read_count;
`endif

    // Digit mux: choose the nibble for the digit being scanned, or blank it.
    always_comb begin
        nibble = 4'h0;
        blank  = 1'b1;
        case (scan_idx)
            3'd0: begin nibble = capture[3:0]; blank = 1'b0; end
            3'd1: begin nibble = capture[7:4]; blank = 1'b0; end
`ifdef FIFO_DISP_COUNT_EN
            3'd4: begin nibble = read_count[3:0]; blank = 1'b0; end
            3'd5: begin nibble = read_count[7:4]; blank = 1'b0; end
`endif
            3'd6: begin nibble = 4'hE; blank = ~rempty; end
            3'd7: begin nibble = 4'hF; blank = ~wfull;  end
            default: ;
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            scan_idx   <= '0;
            capture    <= 8'h00;
            anode      <= 8'hFF;
            seg_q      <= SEG_BLANK;
`ifdef FIFO_DISP_COUNT_EN
            read_count <= 8'h00;
`endif
        end else begin
            if (prescaler == LAST) begin
                prescaler <= '0;
                scan_idx  <= scan_idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (rd_strobe) begin
                capture    <= rdata[7:0];
`ifdef FIFO_DISP_COUNT_EN
                read_count <= read_count + 8'd1;
`endif
            end
            // Outputs reflect the current scan index, so they trail it by one edge.
            anode <= ~(8'd1 << scan_idx);
            seg_q <= blank ? SEG_BLANK : glyph;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_fifo_display_driver.sv
// Randomized self-checking bench for fifo_display_driver with a cycle-count based display model.
module tb_fifo_display_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rdata;
    logic       rd_strobe;
    logic       wfull;
    logic       rempty;
    logic       a, b, c, d, e, f, g;
    logic [7:0] anode;
    logic [6:0] seg;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    fifo_display_driver #(.DSIZE(8), .REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .rdata     (rdata),
        .rd_strobe (rd_strobe),
        .wfull     (wfull),
        .rempty    (rempty),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .anode     (anode)
    );

    assign seg = {a, b, c, d, e, f, g};

    logic [6:0] hex_glyph [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count non-reset edges; digit lit = (edges / DIV) mod 8.
    int         m_cyc;
    int         m_cap;
    int         m_cnt;
    int         m_idx;
    bit         model_valid = 1'b0;
    logic [7:0] exp_anode;
    logic [6:0] exp_seg;

    function automatic logic [6:0] digit_glyph(input int idx, input int cap, input int cnt,
                                               input logic full, input logic empty);
        case (idx)
            0: return hex_glyph[cap % 16];
            1: return hex_glyph[cap / 16];
`ifdef FIFO_DISP_COUNT_EN
            4: return hex_glyph[cnt % 16];
            5: return hex_glyph[cnt / 16];
`endif
            6: return empty ? hex_glyph[14] : 7'h7F;
            7: return full  ? hex_glyph[15] : 7'h7F;
            default: return 7'h7F;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cyc     = 0;
            m_cap     = 0;
            m_cnt     = 0;
            exp_anode = 8'hFF;
            exp_seg   = 7'h7F;
        end else begin
            m_idx     = (m_cyc / DIV) % 8;
            exp_anode = ~(8'd1 << m_idx);
            exp_seg   = digit_glyph(m_idx, m_cap, m_cnt, wfull, rempty);
            m_cyc++;
            if (rd_strobe) begin
                m_cap = int'(rdata);
                m_cnt = (m_cnt + 1) % 256;
            end
        end
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_anode", anode, exp_anode);
            check("model_seg", {1'b0, seg}, {1'b0, exp_seg});
        end
    end

    task automatic wait_anode(input logic [7:0] want, input string name);
        int n;
        n = 0;
        while (anode !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, anode, want);
    endtask

    // Wait until a digit is freshly driven after the preceding digit, then check its glyph.
    task automatic show(input int digit, input logic [6:0] want, input string name);
        wait_anode(~(8'd1 << ((digit + 7) % 8)), "wait_prev_digit");
        wait_anode(~(8'd1 << digit), "wait_digit");
        check(name, {1'b0, seg}, {1'b0, want});
    endtask

    initial begin
        reset     = 1'b1;
        rd_strobe = 1'b0;
        rdata     = 8'h00;
        wfull     = 1'b0;
        rempty    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_anode", anode, 8'hFF);
        check("reset_seg", {1'b0, seg}, 8'h7F);
        reset = 1'b0;
        @(negedge clk);
        check("first_anode", anode, 8'hFE);
        check("first_seg_0", {1'b0, seg}, 8'h01);

        for (int j = 0; j < 36; j++) begin
            check("scan_seq", anode, ~(8'd1 << ((j / DIV) % 8)));
            @(negedge clk);
        end

        rdata     = 8'hA5;
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
        show(0, 7'h24, "digit0_5");
        show(1, 7'h08, "digit1_A");
        show(0, 7'h24, "digit0_hold");
        show(2, 7'h7F, "digit2_blank");
        show(3, 7'h7F, "digit3_blank");

        wfull = 1'b1;
        show(7, 7'h38, "digit7_F");
        show(6, 7'h7F, "digit6_blank");
        rempty = 1'b1;
        show(6, 7'h30, "digit6_E");
        show(7, 7'h38, "digit7_both");

        wait_anode(8'hDF, "wait_digit5");
        reset     = 1'b1;
        rd_strobe = 1'b1;
        rdata     = 8'h3C;
        @(negedge clk);
        check("midscan_reset_anode", anode, 8'hFF);
        check("midscan_reset_seg", {1'b0, seg}, 8'h7F);
        reset     = 1'b0;
        rd_strobe = 1'b0;
        @(negedge clk);
        check("post_reset_anode", anode, 8'hFE);
        check("post_reset_seg_0", {1'b0, seg}, 8'h01);

        for (int i = 0; i < 257; i++) begin
            rdata     = 8'($urandom);
            rd_strobe = 1'b1;
            @(negedge clk);
        end
        rd_strobe = 1'b0;
`ifdef FIFO_DISP_COUNT_EN
        show(4, 7'h4F, "count_lo_1");
        show(5, 7'h01, "count_hi_0");
`else
        show(4, 7'h7F, "digit4_blank");
        show(5, 7'h7F, "digit5_blank");
`endif

        for (int i = 0; i < 3000; i++) begin
            rdata     = 8'($urandom);
            rd_strobe = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) wfull  = ~wfull;
            if ($urandom_range(0, 15) == 0) rempty = ~rempty;
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        reset     = 1'b0;
        rd_strobe = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
